history_window_copier: RTL and testbench

- Next-generation LZRW1 decompressor history stage. Replaces the externally addressed history buffer with a self-managing sliding window.
- Accepts literal and copy (offset, length) commands. Expands copies element by element, including overlapping copies, and writes every produced element back into the window.
- Streams the produced elements out over a valid/ready interface. Sits between the decompressor's token parser and its output packer.

---
 rtl/history_window_copier.sv | 110 +++++++++++
 tb/tb_history_window_copier.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/history_window_copier.sv
// rtl/history_window_copier.sv - LZRW1 history stage: sliding window with literal/copy expansion
module history_window_copier #(
    parameter int  HISTORY_SIZE = 4096,
    parameter int  ENTRY_WIDTH  = 8,
    parameter int  LEN_WIDTH    = 5,
    localparam int ADDR_WIDTH   = $clog2(HISTORY_SIZE)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_copy,
    input  logic [ENTRY_WIDTH-1:0]  cmd_literal,
    input  logic [ADDR_WIDTH:0]     cmd_offset,
    input  logic [LEN_WIDTH-1:0]    cmd_length,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ENTRY_WIDTH-1:0]  out_data,
    output logic                    busy,
    output logic [ADDR_WIDTH:0]     fill_level,
    output logic                    err
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(HISTORY_SIZE);

    typedef enum logic {IDLE, COPY} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  src;
    logic [LEN_WIDTH-1:0]   rem;
    logic [ENTRY_WIDTH-1:0] hist [HISTORY_SIZE];

    logic                   adv;
    logic                   accept;
    logic                   copy_step;
    logic                   wr_en;
    logic                   bad_offset;
    logic [ENTRY_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH:0]    fill_next;

    assign adv        = !out_valid || out_ready;
    assign cmd_ready  = reset && (state == IDLE) && adv && !flush;
    assign accept     = cmd_valid && cmd_ready;
    assign copy_step  = (state == COPY) && adv && !flush;
    assign wr_en      = (accept && !cmd_is_copy) || copy_step;
    // Combinational read: the previous step's write is already visible, which makes overlapping copies work.
    assign wr_data    = copy_step ? hist[src] : cmd_literal;
    assign fill_next  = (fill_level == FULL_LEVEL) ? fill_level : fill_level + (ADDR_WIDTH+1)'(1);
    assign bad_offset = (cmd_offset == '0) || (cmd_offset > fill_level);

    // Window storage is deliberately never cleared; fill_level marks which entries hold real history.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            hist[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            src        <= '0;
            rem        <= '0;
            fill_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            fill_level <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (wr_en) begin
                out_data   <= wr_data;
                out_valid  <= 1'b1;
                wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                fill_level <= fill_next;
            end
            if (copy_step) begin
                src <= src + ADDR_WIDTH'(1);
                rem <= rem - LEN_WIDTH'(1);
                if (rem == LEN_WIDTH'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
            if (accept && cmd_is_copy) begin
                src <= wr_ptr - cmd_offset[ADDR_WIDTH-1:0];
                rem <= cmd_length;
                if (cmd_length != '0) begin
                    state <= COPY;
                    busy  <= 1'b1;
                end
                if (bad_offset) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_history_window_copier.sv
// tb/tb_history_window_copier.sv - scoreboard bench for history_window_copier (16-entry window)
module tb_history_window_copier;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_is_copy = 1'b0;
    logic [7:0] cmd_literal = '0;
    logic [4:0] cmd_offset = '0;
    logic [4:0] cmd_length = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       busy;
    logic [4:0] fill_level;
    logic       err;

    int checks = 0;
    int fails  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_rd = 0;

    history_window_copier #(.HISTORY_SIZE(16), .ENTRY_WIDTH(8), .LEN_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_copy(cmd_is_copy),
        .cmd_literal(cmd_literal), .cmd_offset(cmd_offset), .cmd_length(cmd_length),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .fill_level(fill_level), .err(err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) obs_q.push_back(out_data);
    end

    task automatic send_cmd(input logic c, input logic [7:0] lit, input logic [4:0] off, input logic [4:0] len);
        int n = 0;
        cmd_valid = 1'b1; cmd_is_copy = c; cmd_literal = lit; cmd_offset = off; cmd_length = len;
        @(negedge clock);
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            checks++; fails++;
            $display("FAIL cmd_accept timeout: cmd_ready got 0 expected 1");
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, busy, cmd_ready, err, fill_level, out_data} !== 17'h0) begin
            fails++;
            $display("FAIL reset_state got v=%b b=%b r=%b e=%b f=%0d d=%h expected all 0",
                     out_valid, busy, cmd_ready, err, fill_level, out_data);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release cmd_ready got %b expected 1", cmd_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_literal_stream();
        logic [7:0] e;
        do_flush();
        out_ready = 1'b1;
        exp_q.push_back(8'h41);
        send_cmd(1'b0, 8'h41, 5'd0, 5'd0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h41) begin
            fails++; $display("FAIL lit_latency got v=%b d=%h expected v=1 d=41", out_valid, out_data);
        end
        exp_q.push_back(8'h42); send_cmd(1'b0, 8'h42, 5'd0, 5'd0);
        exp_q.push_back(8'h43); send_cmd(1'b0, 8'h43, 5'd0, 5'd0);
        repeat (3) @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL lit_stream missing element expected %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL lit_stream data got %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin fails++; $display("FAIL lit_stream extra got %0d expected 0", obs_q.size() - obs_rd); end
        checks++;
        if (fill_level !== 5'd3) begin fails++; $display("FAIL lit_fill got %0d expected 3", fill_level); end
    endtask

    task automatic test_overlap_copy();
        logic [7:0] e;
        int busy_cycles = 0;
        do_flush();
        exp_q.push_back(8'h61); send_cmd(1'b0, 8'h61, 5'd0, 5'd0);
        exp_q.push_back(8'h62); send_cmd(1'b0, 8'h62, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++) exp_q.push_back((i % 2 == 0) ? 8'h61 : 8'h62);
        send_cmd(1'b1, 8'h00, 5'd2, 5'd5);
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL overlap missing element expected %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL overlap data got %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin fails++; $display("FAIL overlap extra got %0d expected 0", obs_q.size() - obs_rd); end
        checks++;
        if (busy_cycles != 5) begin fails++; $display("FAIL overlap_busy got %0d expected 5", busy_cycles); end
        checks++;
        if (fill_level !== 5'd7 || err !== 1'b0) begin
            fails++; $display("FAIL overlap_status got fill=%0d err=%b expected fill=7 err=0", fill_level, err);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int ready_while_busy = 0;
        do_flush();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i)); send_cmd(1'b0, 8'(i), 5'd0, 5'd0);
        end
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h01);
        send_cmd(1'b1, 8'h00, 5'd3, 5'd4);
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            @(negedge clock);
            if (busy && cmd_ready) ready_while_busy++;
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if (busy && cmd_ready) ready_while_busy++;
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL backpressure missing element expected %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL backpressure data got %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin fails++; $display("FAIL backpressure extra got %0d expected 0", obs_q.size() - obs_rd); end
        checks++;
        if (ready_while_busy != 0) begin fails++; $display("FAIL backpressure_cmd_ready high-while-busy got %0d expected 0", ready_while_busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        do_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(8'(i)); send_cmd(1'b0, 8'(i), 5'd0, 5'd0);
        end
        exp_q.push_back(8'd4); exp_q.push_back(8'd5); exp_q.push_back(8'd6);
        send_cmd(1'b1, 8'h00, 5'd16, 5'd3);
        repeat (8) @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_rd >= obs_q.size()) begin fails++; $display("FAIL wrap missing element expected %h", e); end
            else begin
                if (obs_q[obs_rd] !== e) begin fails++; $display("FAIL wrap data got %h expected %h", obs_q[obs_rd], e); end
                obs_rd++;
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin fails++; $display("FAIL wrap extra got %0d expected 0", obs_q.size() - obs_rd); end
        checks++;
        if (fill_level !== 5'd16 || err !== 1'b0) begin
            fails++; $display("FAIL wrap_status got fill=%0d err=%b expected fill=16 err=0", fill_level, err);
        end
        checks++;
        if (dut.wr_ptr !== 4'd7) begin fails++; $display("FAIL wrap_wr_ptr got %0d expected 7", dut.wr_ptr); end
    endtask

    task automatic test_errors_noop();
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        obs_rd = obs_q.size();
        send_cmd(1'b1, 8'h00, 5'd1, 5'd2);
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (err !== 1'b1) begin fails++; $display("FAIL err_offset_beyond_fill got %b expected 1", err); end
        checks++;
        if (obs_q.size() - obs_rd != 2) begin fails++; $display("FAIL err_copy_count got %0d expected 2", obs_q.size() - obs_rd); end
        do_flush();
        checks++;
        if (err !== 1'b0 || fill_level !== 5'd0) begin
            fails++; $display("FAIL flush_clear got err=%b fill=%0d expected err=0 fill=0", err, fill_level);
        end
        send_cmd(1'b1, 8'h00, 5'd0, 5'd1);
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (err !== 1'b1) begin fails++; $display("FAIL err_offset_zero got %b expected 1", err); end
        checks++;
        if (obs_q.size() - obs_rd != 1) begin fails++; $display("FAIL err_zero_count got %0d expected 1", obs_q.size() - obs_rd); end
        do_flush();
        send_cmd(1'b0, 8'h55, 5'd0, 5'd0);
        send_cmd(1'b1, 8'h00, 5'd1, 5'd0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if (obs_q.size() - obs_rd != 1) begin fails++; $display("FAIL noop_count got %0d expected 1", obs_q.size() - obs_rd); end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b0) begin
            fails++; $display("FAIL noop_state got busy=%b ready=%b err=%b expected 0 1 0", busy, cmd_ready, err);
        end
        do_flush();
    endtask

    task automatic test_abort_mid_copy();
        int n;
        do_flush();
        send_cmd(1'b0, 8'h10, 5'd0, 5'd0);
        send_cmd(1'b1, 8'h00, 5'd1, 5'd20);
        n = 0;
        while (obs_q.size() < obs_rd + 6 && n < 60) begin
            @(negedge clock); #1; n++;
        end
        checks++;
        if (obs_q.size() < obs_rd + 6) begin fails++; $display("FAIL abort_reset_wait got %0d elements expected 6", obs_q.size() - obs_rd); end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL abort_reset got v=%b busy=%b expected 0 0", out_valid, busy);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        obs_rd = obs_q.size();
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (obs_q.size() != obs_rd || out_valid !== 1'b0) begin
            fails++; $display("FAIL abort_reset_quiet got %0d extra v=%b expected 0 extra v=0", obs_q.size() - obs_rd, out_valid);
        end
        send_cmd(1'b0, 8'h20, 5'd0, 5'd0);
        send_cmd(1'b1, 8'h00, 5'd1, 5'd20);
        n = 0;
        while (obs_q.size() < obs_rd + 6 && n < 60) begin
            @(negedge clock); #1; n++;
        end
        checks++;
        if (obs_q.size() < obs_rd + 6) begin fails++; $display("FAIL abort_flush_wait got %0d elements expected 6", obs_q.size() - obs_rd); end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fill_level !== 5'd0) begin
            fails++; $display("FAIL abort_flush got v=%b busy=%b fill=%0d expected 0 0 0", out_valid, busy, fill_level);
        end
        send_cmd(1'b0, 8'h77, 5'd0, 5'd0);
        checks++;
        if (dut.hist[0] !== 8'h77 || fill_level !== 5'd1) begin
            fails++; $display("FAIL abort_flush_addr0 got hist0=%h fill=%0d expected 77 1", dut.hist[0], fill_level);
        end
        repeat (2) @(posedge clock);
        #1;
        obs_rd = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_literal_stream();
        test_overlap_copy();
        test_backpressure();
        test_wrap();
        test_errors_noop();
        test_abort_mid_copy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
